// File: rtl/data_memory_responder_if.sv
// Request/response bus for data_memory_responder.
// Master drives the request; slave answers with a one-cycle response.
interface data_memory_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with fixed-latency single-beat responses.
// Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                    clk_i,
  input logic                    rst_i,
  data_memory_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] hold_q;
  logic        herr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic             ready;
  logic             accept;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word_now;

  assign idx = bus.addr_i[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign addr_err = (|bus.addr_i[1:0])
                  | (|bus.addr_i[31:IDX_W+2]);
`else
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:IDX_W+2],
                         bus.addr_i[1:0]};
  assign addr_err = 1'b0;
`endif

  assign ready  = (state_q == IDLE) && !rst_i;
  assign accept = bus.req_i && ready;

  // Writes and errors answer with zero data
  assign word_now = (bus.we_i || addr_err) ? 32'h0
                                           : mem[idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = LOAD;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= 32'h0;
      herr_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hold_q <= word_now;
        herr_q <= addr_err;
      end
      // LATENCY=1 enters RESP straight from IDLE
      if (state_d == RESP) begin
        rdata_q <= (state_q == IDLE) ? word_now : hold_q;
        err_q   <= (state_q == IDLE) ? addr_err : herr_q;
      end else begin
        err_q <= 1'b0;
      end
    end
  end

  // Array is never reset
  always_ff @(posedge clk_i) begin
    if (accept && bus.we_i && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.rvalid_o = (state_q == RESP) && !rst_i;
  assign bus.err_o    = err_q && bus.rvalid_o;
  assign bus.rdata_o  = rst_i ? 32'h0 : rdata_q;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words in the array (power of two, 4..4096).
REQ-002 Parameter LATENCY, default 2, SHALL set the number of cycles from request accept to response (1..15).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_i  input  1  SHALL request an access; qualified by ready_o.
REQ-006 we_i  input  1  SHALL select write (1) or read (0) for the request.
REQ-007 addr_i  input  32  SHALL carry the byte address.
REQ-008 wdata_i  input  32  SHALL carry the write data.
REQ-009 be_i  input  4  SHALL carry the byte-lane write enables; bit n selects wdata_i[8n+7:8n].
REQ-010 ready_o  output  1  SHALL indicate that a request can be accepted this cycle.
REQ-011 rvalid_o  output  1  SHALL mark a one-cycle response.
REQ-012 rdata_o  output  32  SHALL carry the read data for the response.
REQ-013 err_o  output  1  SHALL flag an error response; valid only with rvalid_o.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and RESP; ready_o SHALL be 1 only in IDLE while rst_i is 0.
REQ-015 A request SHALL be accepted on the edge where req_i=1 and ready_o=1; req_i is ignored in BUSY and RESP.
REQ-016 On accept, the word index SHALL be addr_i[log2(DEPTH_WORDS)+1:2].
REQ-017 On an accepted write, lanes with be_i=1 SHALL update at the accept edge; be_i=0000 SHALL write nothing but still respond.
REQ-018 On an accepted read, the word SHALL be captured into the response register at the accept edge.
REQ-019 The accept edge SHALL transition IDLE->BUSY and load the counter with LATENCY-1; for LATENCY=1, IDLE->RESP directly.
REQ-020 In BUSY the counter SHALL decrement each cycle; at 0 the state SHALL go to RESP.
REQ-021 In RESP rvalid_o SHALL be 1 for exactly one cycle, then IDLE; rvalid_o SHALL be high in the LATENCY-th cycle after the accept edge.
REQ-022 rdata_o SHALL be the captured word for a read and 32'h0 for a write; rdata_o SHALL hold its value when rvalid_o=0.
REQ-023 Back-to-back: the earliest next accept SHALL be on the edge ending the RESP cycle's successor IDLE cycle (throughput of one access per LATENCY+1 cycles).

Reset
REQ-024 While rst_i=1: state SHALL be IDLE, counter 0, rvalid_o 0, err_o 0, rdata_o 32'h0, ready_o 0, and req_i ignored.
REQ-025 Reset in BUSY or RESP SHALL abort the transaction with no response; a write already accepted SHALL remain in the array.
REQ-026 The array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With DMEM_ERR_CHECK_EN defined: addr_i[1:0]!=0 or a word index >= DEPTH_WORDS SHALL produce err_o=1 with rvalid_o, suppress the write, and return rdata_o=32'h0.
REQ-028 Without DMEM_ERR_CHECK_EN: err_o SHALL be tied to 0, addr_i[1:0] and bits above the index SHALL be ignored (address wraps), and the access SHALL proceed.

Verification
REQ-029 LATENCY=2: write addr 0x10, data 0xDEADBEEF, be 1111 at edge T -> rvalid_o=1 with rdata_o=0 in the cycle after T+1, ready_o=0 during T+1..T+2.
REQ-030 Read 0x10 after REQ-029 -> rdata_o=0xDEADBEEF, err_o=0, rvalid_o high for exactly one cycle.
REQ-031 Write 0x10 data 0x11223344 with be 0101, then read -> 0xDE22BE44.
REQ-032 Assert rst_i for one cycle in BUSY -> no rvalid_o pulse, ready_o=1 in the cycle after reset deasserts, and the written word is still readable.
REQ-033 DMEM_ERR_CHECK_EN defined: read 0x13 -> err_o=1, rdata_o=0; write 0x400 (DEPTH_WORDS=256) -> err_o=1 and word 0 is unchanged.
REQ-034 Macro undefined: write 0x400 data 0xCAFEF00D, then read 0x0 -> 0xCAFEF00D with err_o=0.
